// File: rtl/etpu_pkg.sv
// Shared definitions for the edu TPU GPIO stream bridge.
// Contents:
//   chunk_count()  - number of lane-wide chunks that make up a word
//   ptr_width()    - FIFO pointer width for a given depth
//   IN_CHUNKS_DEF, RES_CHUNKS_DEF, PTR_W_DEF - values for the default
//                    parameter set (8/2, 16/2, depth 4)
//   serial_state_t - serializer FSM states
package etpu_pkg;

  function automatic int chunk_count(input int width, input int lanes);
    return width / lanes;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int IN_CHUNKS_DEF  = 8 / 2;
  localparam int RES_CHUNKS_DEF = 16 / 2;
  localparam int PTR_W_DEF      = 2;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } serial_state_t;

endpackage

// File: rtl/etpu_sync_fifo.sv
// Synchronous FIFO that buffers deserialised inbound words.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   push, push_data write request and its word
//   pop             read request; ignored while empty
//   head, valid     registered head entry and its valid flag
//   fill            occupancy, 0..DEPTH
//   rejected        one-cycle pulse when a push is dropped because the FIFO is full
module etpu_sync_fifo
  import etpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       rejected
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int FW    = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FW-1:0]     count;
  logic              full;
  logic              empty;
  logic              pop_ok;
  logic              push_ok;

  assign full  = (count == FW'(DEPTH));
  assign empty = (count == '0);

  // A pop in the same cycle frees the head slot, so a push into a full FIFO
  // still lands when the core is taking a word.
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign rejected = push & ~push_ok;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem[gi] <= '0;
        end else if (push_ok && (wr_ptr == PTR_W'(gi))) begin
          mem[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = ~empty;
  assign fill  = count;

endmodule

// File: rtl/etpu_gpio_stream_bridge.sv
// GPIO-to-core bridge for the edu TPU: serial inbound lanes are assembled
// into words, queued and offered to the core; core results are shifted out
// on serial outbound lanes with a strobe.
// Ports:
//   clk, RSTB              clock and asynchronous active-low reset
//   in_frame/in_strb/in_data   inbound serial chunks, MSB chunk first
//   m_valid/m_ready/m_data     FIFO head to the core
//   s_valid/s_ready/s_data     result word from the core
//   out_strb/out_data          outbound serial chunks, MSB chunk first
//   ovf                        sticky overflow (word dropped on full FIFO)
//   fill                       FIFO occupancy
module etpu_gpio_stream_bridge
  import etpu_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int IN_LANES  = 2,
  parameter int DEPTH     = 4,
  parameter int RES_W     = 16,
  parameter int OUT_LANES = 2
) (
  input  logic                   clk,
  input  logic                   RSTB,
  input  logic                   in_frame,
  input  logic                   in_strb,
  input  logic [IN_LANES-1:0]    in_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_W-1:0]      m_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [RES_W-1:0]       s_data,
  output logic                   out_strb,
  output logic [OUT_LANES-1:0]   out_data,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int IN_CHUNKS  = chunk_count(DATA_W, IN_LANES);
  localparam int RES_CHUNKS = chunk_count(RES_W, OUT_LANES);
  localparam int ICW        = (IN_CHUNKS > 1) ? $clog2(IN_CHUNKS) : 1;
  localparam int SCW        = $clog2(RES_CHUNKS + 1);

  // ---------------- deserializer ----------------
  logic [DATA_W-1:0]          shreg;
  logic [ICW-1:0]             icnt;
  logic [DATA_W+IN_LANES-1:0] shcat;
  logic                       take;
  logic                       last_chunk;
  logic                       push;
  logic                       rejected;

  assign shcat      = {shreg, in_data};
  assign take       = in_frame & in_strb;
  assign last_chunk = (icnt == ICW'(IN_CHUNKS - 1));
  // The word is pushed in the same cycle its last chunk arrives.
  assign push       = take & last_chunk;

  always_ff @(posedge clk or negedge RSTB) begin
    if (!RSTB) begin
      shreg <= '0;
      icnt  <= '0;
    end else if (!in_frame) begin
      icnt <= '0;
    end else if (in_strb) begin
      shreg <= shcat[DATA_W-1:0];
      icnt  <= last_chunk ? '0 : icnt + 1'b1;
    end
  end

  etpu_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (RSTB),
    .push      (push),
    .push_data (shcat[DATA_W-1:0]),
    .pop       (m_valid & m_ready),
    .head      (m_data),
    .valid     (m_valid),
    .fill      (fill),
    .rejected  (rejected)
  );

  always_ff @(posedge clk or negedge RSTB) begin
    if (!RSTB) ovf <= 1'b0;
    else if (rejected) ovf <= 1'b1;
  end

  // ---------------- serializer ----------------
  serial_state_t    state;
  logic [RES_W-1:0] sreg;
  logic [SCW-1:0]   scnt;

  // The first chunk is emitted straight from s_data on acceptance, so sreg
  // always holds the remaining chunks and scnt counts chunks already shown.
  always_ff @(posedge clk or negedge RSTB) begin
    if (!RSTB) begin
      state    <= S_IDLE;
      sreg     <= '0;
      scnt     <= '0;
      s_ready  <= 1'b1;
      out_strb <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (s_valid) begin
            out_data <= s_data[RES_W-1 -: OUT_LANES];
            out_strb <= 1'b1;
            sreg     <= s_data << OUT_LANES;
            scnt     <= SCW'(1);
            s_ready  <= 1'b0;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (scnt == SCW'(RES_CHUNKS)) begin
            out_strb <= 1'b0;
            out_data <= '0;
            s_ready  <= 1'b1;
            state    <= S_IDLE;
          end else begin
            out_data <= sreg[RES_W-1 -: OUT_LANES];
            sreg     <= sreg << OUT_LANES;
            scnt     <= scnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_etpu_gpio_stream_bridge.sv
// Directed testbench for etpu_gpio_stream_bridge with scoreboard queues for
// inbound words and outbound chunks.
module tb_etpu_gpio_stream_bridge;

  localparam int DATA_W    = 8;
  localparam int IN_LANES  = 2;
  localparam int DEPTH     = 4;
  localparam int RES_W     = 16;
  localparam int OUT_LANES = 2;

  logic                   clk = 1'b0;
  logic                   RSTB;
  logic                   in_frame, in_strb;
  logic [IN_LANES-1:0]    in_data;
  logic                   m_valid, m_ready;
  logic [DATA_W-1:0]      m_data;
  logic                   s_valid, s_ready;
  logic [RES_W-1:0]       s_data;
  logic                   out_strb;
  logic [OUT_LANES-1:0]   out_data;
  logic                   ovf;
  logic [$clog2(DEPTH):0] fill;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0]    in_q[$];
  logic [OUT_LANES-1:0] out_q[$];

  always #5 clk = ~clk;

  etpu_gpio_stream_bridge #(
    .DATA_W(DATA_W), .IN_LANES(IN_LANES), .DEPTH(DEPTH),
    .RES_W(RES_W), .OUT_LANES(OUT_LANES)
  ) dut (
    .clk(clk), .RSTB(RSTB),
    .in_frame(in_frame), .in_strb(in_strb), .in_data(in_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .out_strb(out_strb), .out_data(out_data),
    .ovf(ovf), .fill(fill)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_chunk(input logic [IN_LANES-1:0] c);
    in_frame = 1'b1;
    in_strb  = 1'b1;
    in_data  = c;
    tick();
    in_strb  = 1'b0;
  endtask

  // store: the word is expected to enter the FIFO; pop_last: raise m_ready
  // in the cycle the last chunk lands.
  task automatic send_word(input logic [DATA_W-1:0] w, input bit store, input bit pop_last);
    logic [DATA_W-1:0] t;
    t = w;
    if (store) in_q.push_back(w);
    for (int i = 0; i < DATA_W / IN_LANES; i++) begin
      in_frame = 1'b1;
      in_strb  = 1'b1;
      in_data  = t[DATA_W-1 -: IN_LANES];
      t        = t << IN_LANES;
      if (pop_last && i == DATA_W / IN_LANES - 1) m_ready = 1'b1;
      tick();
      in_strb = 1'b0;
      if (pop_last) m_ready = 1'b0;
    end
  endtask

  task automatic send_result(input logic [RES_W-1:0] d);
    int n;
    logic [RES_W-1:0] t;
    n = 0;
    while (s_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("s_ready_wait_bound", 32'(n < 50), 32'd1);
    t = d;
    for (int i = 0; i < RES_W / OUT_LANES; i++) begin
      out_q.push_back(t[RES_W-1 -: OUT_LANES]);
      t = t << OUT_LANES;
    end
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_ready = 1'b1;
    while (fill !== '0 && n < 20) begin
      tick();
      n++;
    end
    m_ready = 1'b0;
    check("drain_bound", 32'(n < 20), 32'd1);
  endtask

  // Scoreboard monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (RSTB === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (in_q.size() == 0) begin
        check("unexpected_m_word", 32'(m_data), 32'hFFFF_FFFF);
      end else begin
        logic [DATA_W-1:0] e;
        e = in_q.pop_front();
        $display("inbound pop: m_data=%02h expected=%02h", m_data, e);
        check("m_data_pop", 32'(m_data), 32'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (RSTB === 1'b1 && out_strb === 1'b1) begin
      if (out_q.size() == 0) begin
        check("unexpected_out_strb", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        logic [OUT_LANES-1:0] e;
        e = out_q.pop_front();
        $display("outbound chunk: out_data=%0d expected=%0d", out_data, e);
        check("out_data_chunk", 32'(out_data), 32'(e));
      end
    end
  end

  initial begin
    RSTB = 1'b0; in_frame = 1'b0; in_strb = 1'b0; in_data = '0;
    m_ready = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_out_strb", 32'(out_strb), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    RSTB = 1'b1;
    tick();

    // 1. Reset mid-word discards the partial chunks.
    send_chunk(2'b11);
    send_chunk(2'b11);
    RSTB = 1'b0;
    in_q.delete();
    out_q.delete();
    tick();
    RSTB = 1'b1;
    check("rst_mid_fill", 32'(fill), 32'd0);
    send_word(8'h05, 1, 0);
    check("rst_mid_m_valid", 32'(m_valid), 32'd1);
    check("rst_mid_head", 32'(m_data), 32'h05);
    drain();
    in_frame = 1'b0;

    // 1b. Reset during SHIFT.
    send_result(16'hFFFF);
    tick();
    tick();
    check("shift_strb_before_rst", 32'(out_strb), 32'd1);
    RSTB = 1'b0;
    #1;
    check("shift_rst_out_strb", 32'(out_strb), 32'd0);
    check("shift_rst_s_ready", 32'(s_ready), 32'd1);
    out_q.delete();
    in_q.delete();
    tick();
    RSTB = 1'b1;
    tick();

    // 2. Single inbound word with one-cycle latency.
    send_chunk(2'b10);
    send_chunk(2'b11);
    send_chunk(2'b00);
    check("single_no_valid_early", 32'(m_valid), 32'd0);
    in_q.push_back(8'hB1);
    send_chunk(2'b01);
    check("single_m_valid", 32'(m_valid), 32'd1);
    check("single_m_data", 32'(m_data), 32'hB1);
    check("single_fill", 32'(fill), 32'd1);
    drain();
    check("single_fill_after", 32'(fill), 32'd0);

    // 3. Frame abort: strobe with in_frame low is ignored.
    send_chunk(2'b01);
    send_chunk(2'b10);
    send_chunk(2'b11);
    in_frame = 1'b0; in_strb = 1'b1; in_data = 2'b00;
    tick();
    in_strb = 1'b0;
    send_word(8'hFF, 1, 0);
    check("abort_fill", 32'(fill), 32'd1);
    check("abort_head", 32'(m_data), 32'hFF);
    drain();

    // 4. Overflow then simultaneous push/pop at full.
    send_word(8'h11, 1, 0);
    send_word(8'h22, 1, 0);
    send_word(8'h33, 1, 0);
    send_word(8'h44, 1, 0);
    check("full_fill", 32'(fill), 32'd4);
    check("full_no_ovf", 32'(ovf), 32'd0);
    send_word(8'h55, 0, 0);
    check("ovf_fill", 32'(fill), 32'd4);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_head", 32'(m_data), 32'h11);
    send_word(8'h66, 1, 1);
    check("full_pushpop_fill", 32'(fill), 32'd4);
    check("full_pushpop_head", 32'(m_data), 32'h22);
    drain();
    check("ovf_sticky", 32'(ovf), 32'd1);
    in_frame = 1'b0;

    // 5. Serializer timing for 16'hA5C3.
    send_result(16'hA5C3);
    for (int i = 0; i < RES_W / OUT_LANES; i++) begin
      check("ser_strb_high", 32'(out_strb), 32'd1);
      check("ser_s_ready_low", 32'(s_ready), 32'd0);
      tick();
    end
    check("ser_strb_end", 32'(out_strb), 32'd0);
    check("ser_s_ready_end", 32'(s_ready), 32'd1);
    check("ser_chunks_left", 32'(out_q.size()), 32'd0);

    // 6. Concurrent inbound stream and back-to-back results.
    fork
      begin
        m_ready = 1'b1;
        send_word(8'h3C, 1, 0);
        send_word(8'hC3, 1, 0);
        send_word(8'h5A, 1, 0);
      end
      begin
        send_result(16'h1234);
        send_result(16'hFEDC);
      end
    join
    repeat (12) tick();
    m_ready = 1'b0;
    check("conc_in_q_empty", 32'(in_q.size()), 32'd0);
    check("conc_out_q_empty", 32'(out_q.size()), 32'd0);
    check("conc_fill", 32'(fill), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/etpu_gpio_stream_bridge.md
Name: etpu_gpio_stream_bridge

Overview:
Parametrised GPIO-to-core bridge for the edu TPU user project. It replaces the fixed two-input / two-output mprj_io pin mapping with configurable-width serial lanes. Inbound lane bits are deserialised into DATA_W words, buffered in a DEPTH-entry FIFO and presented to the TPU core over valid/ready. TPU result words are accepted over valid/ready and serialised back out on OUT_LANES pins with a strobe.

Parameters:
DATA_W, 8, inbound word width; must be a multiple of IN_LANES
IN_LANES, 2, inbound serial data pins per strobe
DEPTH, 4, inbound FIFO entries; power of two, >= 2
RES_W, 16, result word width; must be a multiple of OUT_LANES
OUT_LANES, 2, outbound serial data pins per strobe

Ports:
clk  in  1  system clock
RSTB  in  1  asynchronous active-low reset
in_frame  in  1  high while an inbound word is in progress; low clears the partial word
in_strb  in  1  one chunk valid on in_data this cycle
in_data  in  IN_LANES  inbound chunk, MSB chunk first
m_valid  out  1  FIFO head word valid to core
m_ready  in  1  core accepts head word
m_data  out  DATA_W  FIFO head word
s_valid  in  1  core offers result
s_ready  out  1  serializer idle, can accept
s_data  in  RES_W  result word
out_strb  out  1  out_data chunk valid
out_data  out  OUT_LANES  outbound chunk, MSB chunk first
ovf  out  1  sticky: a completed word was dropped because the FIFO was full
fill  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (RSTB low, asynchronous): m_valid=0, m_data=0, s_ready=1, out_strb=0, out_data=0, ovf=0, fill=0. The chunk counter, FIFO pointers and serializer state are cleared. A partial inbound word or an in-flight result is discarded. All inputs are synchronous to clk.
- Deserializer: shift register plus chunk counter 0..DATA_W/IN_LANES-1.
  - When in_frame=1 and in_strb=1: shreg <= {shreg, in_data} and the counter increments.
  - When in_frame=0: the counter resets to 0 and in_strb is ignored.
  - On the last chunk, the assembled word is pushed to the FIFO in the same cycle, and the counter wraps to 0 while in_frame stays high. Back-to-back words need no frame gap.
- FIFO:
  - Push-to-m_valid latency is 1 clk; m_data is the registered head.
  - Pop happens when m_valid & m_ready.
  - Push and pop in the same cycle: fill is unchanged. This includes the full case, because the pop frees a slot first, so the push is accepted.
  - Push when full with no pop: the word is dropped, ovf <= 1, and ovf is cleared only by reset.
  - Pop when empty cannot happen, because m_valid=0.
  - Pointers wrap modulo DEPTH.
- Serializer FSM, two states:
  - IDLE: s_ready=1, out_strb=0. On s_valid, latch s_data, go to SHIFT and set s_ready=0 in the next cycle.
  - SHIFT: each cycle out_strb=1 and out_data=top OUT_LANES bits, then shift left by OUT_LANES. The chunk count is RES_W/OUT_LANES. After the last chunk, return to IDLE, where s_ready=1 in the following cycle.
  - First out_strb appears 1 clk after acceptance. A full word takes RES_W/OUT_LANES consecutive strobe cycles.
  - Minimum result period is RES_W/OUT_LANES+1 cycles.
- Inbound and outbound paths are fully independent and may operate in the same cycle.

Decomposition:
- Shared package etpu_pkg holds:
  - localparams for chunk counts, DATA_W/IN_LANES and RES_W/OUT_LANES;
  - the FIFO pointer width $clog2(DEPTH);
  - the serializer state enum {S_IDLE, S_SHIFT}.
- One sub-module is natural: etpu_sync_fifo (parametrised DATA_W, DEPTH). It owns fill and full/empty, and reports a push-rejected pulse that the top uses to set ovf.
- Deserializer and serializer stay in the top.

Test Plan:
1. Reset mid-operation: with DATA_W=8 and IN_LANES=2, deliver 2 chunks, assert RSTB low for 1 cycle, then send chunks 0,0,1,1 -> head word is 8'h05 and the stale chunks are gone. Also assert RSTB during SHIFT -> out_strb drops immediately and s_ready=1.
2. Single inbound word: in_frame=1, four strobes of chunks 2'b10,2'b11,2'b00,2'b01 -> m_valid rises 1 clk after the 4th strobe with m_data=8'hB1, and fill=1.
3. Frame abort: send 3 chunks, drop in_frame for 1 cycle, then send 4 chunks of 2'b11 -> exactly one word, 8'hFF, is pushed.
4. Overflow and simultaneous push/pop:
   - With m_ready=0, push 5 words -> fill=4 and ovf=1, and the FIFO holds the first 4.
   - With the FIFO full, complete a word in the same cycle m_ready=1 -> fill stays 4 and the new word is stored.
5. Serializer: s_data=16'hA5C3 with s_valid for 1 cycle -> out_strb high for 8 consecutive cycles starting 1 clk later, with out_data sequence 2,2,1,1,3,0,0,3. s_ready is low throughout and high 1 clk after the last chunk.
6. Concurrency: stream 3 inbound words while serializing 2 back-to-back results -> all words arrive in order, and the results are serialized without corruption.
